// File: rtl/huffman_stream_decoder.sv
// huffman_stream_decoder: canonical-Huffman decoder, MSB-first word input, one symbol per codeword out.
// Code table is loaded at runtime as per-length counts plus a symbol list.
module huffman_stream_decoder #(
    parameter int SYM_W = 8,
    parameter int NSYM = 256,
    parameter int MAX_LEN = 16,
    parameter int IN_W = 8,
    localparam int IDX_W = $clog2(NSYM),
    localparam int LEN_W = $clog2(MAX_LEN + 1),
    localparam int CFG_W = (SYM_W > IDX_W + 1) ? SYM_W : IDX_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_en,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [CFG_W-1:0] cfg_wdata,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [SYM_W-1:0] sym_data,
    output logic             sym_valid,
    input  logic             sym_ready,
    output logic             busy,
    output logic             err
);
    localparam int W = MAX_LEN + 1;
    localparam int BW = $clog2(IN_W + 1);

    typedef enum logic [1:0] {IDLE, DECODE, OUT, ERR} state_t;
    state_t state, state_nx;

    logic [IDX_W:0]   counts [1:MAX_LEN];
    logic [SYM_W-1:0] syms [NSYM];
    logic [IN_W-1:0]  bits;
    logic [BW-1:0]    bit_cnt;
    logic [W-1:0]     code, first, index, c, cnt, off;
    logic [W:0]       sum;
    logic [LEN_W-1:0] len;
    logic abort, consume, match, ovf, last, take, restart;

    assign abort = state != IDLE && !dec_en;
    assign consume = state == DECODE && bit_cnt != 0 && dec_en;
    assign c = W'({code, bits[IN_W-1]});
    assign cnt = W'(counts[len]);
    assign off = c - first;
    assign match = c >= first && off < cnt;
    assign sum = {1'b0, index} + {1'b0, off};
    assign ovf = sum >= (W + 1)'(NSYM);
    assign last = len == LEN_W'(MAX_LEN);
    assign in_ready = bit_cnt == 0 && (state == DECODE || state == OUT);
    assign take = in_valid && in_ready;
    assign restart = dec_en && (state == IDLE || (state == OUT && sym_ready));
    assign sym_valid = state == OUT;
    assign busy = state != IDLE;
    assign err = state == ERR;

    always_comb begin
        state_nx = state;
        if (abort)
            state_nx = IDLE;
        else
            case (state)
                IDLE:    state_nx = dec_en ? DECODE : IDLE;
                DECODE:  if (consume) state_nx = match ? (ovf ? ERR : OUT) : (last ? ERR : DECODE);
                OUT:     state_nx = sym_ready ? DECODE : OUT;
                default: state_nx = state;
            endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= IDLE;
        else state <= state_nx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bits <= '0;
            bit_cnt <= '0;
            code <= '0;
            first <= '0;
            index <= '0;
            len <= '0;
            sym_data <= '0;
        end else begin
            if (abort)
                bit_cnt <= '0;
            else if (take) begin
                bits <= in_data;
                bit_cnt <= BW'(IN_W);
            end else if (consume) begin
                bits <= bits << 1;
                bit_cnt <= bit_cnt - BW'(1);
            end
            if (restart) begin
                code <= '0;
                first <= '0;
                index <= '0;
                len <= LEN_W'(1);
            end else if (consume && match) begin
                if (!ovf) sym_data <= syms[sum[IDX_W-1:0]];
            end else if (consume && !last) begin
                first <= (first + cnt) << 1;
                index <= index + cnt;
                code <= c;
                len <= len + LEN_W'(1);
            end
        end
    end

    // Table writes only land while idle so a running decode never sees a half-updated code.
    always_ff @(posedge clk)
        if (cfg_we && state == IDLE) begin
            if (cfg_sel)
                syms[cfg_addr] <= cfg_wdata[SYM_W-1:0];
            else if (cfg_addr != 0 && 32'(cfg_addr) <= MAX_LEN)
                counts[LEN_W'(cfg_addr)] <= cfg_wdata[IDX_W:0];
        end
endmodule
